// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, on magnitudes) unit.
// Loads the HI/LO pair 32 edges after a start and flags divide-by-zero without starting.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multStart,
   input  logic             divStart,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   accReg;
   logic [WIDTH-1:0] qReg;
   logic             qm1;
   logic [WIDTH-1:0] opReg;
   logic             signA;
   logic             signB;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic             lastIter;

   logic [WIDTH:0]   mcandExt;
   logic [WIDTH:0]   boothSum;
   logic [WIDTH:0]   boothAcc;
   logic [WIDTH-1:0] boothQ;
   logic             boothQm1;

   logic [WIDTH:0]   divShift;
   logic [WIDTH+1:0] divDiff;
   logic             divOk;
   logic [WIDTH-1:0] divRem;
   logic [WIDTH-1:0] divQuot;
   logic [WIDTH-1:0] quotFinal;
   logic [WIDTH-1:0] remFinal;

   assign absA     = srcA[WIDTH-1] ? -srcA : srcA;
   assign absB     = srcB[WIDTH-1] ? -srcB : srcB;
   assign lastIter = (count == CNT_W'(WIDTH - 1));

   // The accumulator is one bit wider than the operand so that subtracting a
   // multiplicand of -2^(WIDTH-1) cannot overflow before the arithmetic shift.
   always_comb begin
      mcandExt = {opReg[WIDTH-1], opReg};
      boothSum = accReg;
      case ({qReg[0], qm1})
         2'b01:   boothSum = accReg + mcandExt;
         2'b10:   boothSum = accReg - mcandExt;
         default: boothSum = accReg;
      endcase
      boothAcc = {boothSum[WIDTH], boothSum[WIDTH:1]};
      boothQ   = {boothSum[0], qReg[WIDTH-1:1]};
      boothQm1 = qReg[0];
   end

   // Restoring step: the partial remainder is always below the divisor, so it
   // fits in WIDTH bits; the trial difference carries an extra sign bit.
   always_comb begin
      divShift  = {accReg[WIDTH-1:0], qReg[WIDTH-1]};
      divDiff   = {1'b0, divShift} - {2'b00, opReg};
      divOk     = ~divDiff[WIDTH+1];
      divRem    = divOk ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      divQuot   = {qReg[WIDTH-2:0], divOk};
      quotFinal = (signA ^ signB) ? -divQuot : divQuot;
      remFinal  = signA ? -divRem : divRem;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         accReg <= '0;
         qReg   <= '0;
         qm1    <= 1'b0;
         opReg  <= '0;
         signA  <= 1'b0;
         signB  <= 1'b0;
         hiOut  <= '0;
         loOut  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         case (state)
            IDLE: begin
               if (multStart) begin
                  opReg  <= srcA;
                  qReg   <= srcB;
                  accReg <= '0;
                  qm1    <= 1'b0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= MULT;
               end else if (divStart) begin
                  if (srcB == '0) begin
                     div0 <= 1'b1;
                  end else begin
                     opReg  <= absB;
                     qReg   <= absA;
                     signA  <= srcA[WIDTH-1];
                     signB  <= srcB[WIDTH-1];
                     accReg <= '0;
                     count  <= '0;
                     busy   <= 1'b1;
                     state  <= DIV;
                  end
               end
            end
            MULT: begin
               accReg <= boothAcc;
               qReg   <= boothQ;
               qm1    <= boothQm1;
               count  <= count + CNT_W'(1);
               if (lastIter) begin
                  hiOut <= boothAcc[WIDTH-1:0];
                  loOut <= boothQ;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DIV: begin
               accReg <= {1'b0, divRem};
               qReg   <= divQuot;
               count  <= count + CNT_W'(1);
               if (lastIter) begin
                  hiOut <= remFinal;
                  loOut <= quotFinal;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected HI/LO into a queue,
// a negedge monitor pops and compares on every done or div0 pulse.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        multStart;
   logic        divStart;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [31:0] hiOut;
   logic [31:0] loOut;
   logic        busy;
   logic        done;
   logic        div0;

   typedef struct {
      logic        isDiv0;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .multStart (multStart),
      .divStart  (divStart),
      .srcA      (srcA),
      .srcB      (srcB),
      .hiOut     (hiOut),
      .loOut     (loOut),
      .busy      (busy),
      .done      (done),
      .div0      (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && (done || div0)) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: got done=%0b div0=%0b, expected no pulse at %0t",
                     done, div0, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("pulse_kind", {31'b0, div0}, {31'b0, e.isDiv0});
            checkOutput("hiOut", hiOut, e.hi);
            checkOutput("loOut", loOut, e.lo);
         end
      end
   end

   task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                                input logic expDiv0, input logic [31:0] eh, input logic [31:0] el,
                                input int injectAt);
      int   lat;
      logic busyOk;
      exp_t e;
      @(negedge clk);
      multStart = m;
      divStart  = d;
      srcA      = a;
      srcB      = b;
      e.isDiv0  = expDiv0;
      e.hi      = eh;
      e.lo      = el;
      sb.push_back(e);
      @(negedge clk);
      multStart = 1'b0;
      divStart  = 1'b0;
      if (expDiv0) begin
         checkOutput("div0_busy", {31'b0, busy}, 32'd0);
         checkOutput("div0_set", {31'b0, div0}, 32'd1);
         @(negedge clk);
         checkOutput("div0_clear", {31'b0, div0}, 32'd0);
         checkOutput("div0_no_done", {31'b0, done}, 32'd0);
      end else begin
         checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
         lat    = 0;
         busyOk = 1'b1;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
               lat = k;
               break;
            end
            if (!busy) busyOk = 1'b0;
            divStart = (k == injectAt);
         end
         divStart = 1'b0;
         checkOutput("latency", 32'(lat), 32'd32);
         checkOutput("busy_held", {31'b0, busyOk}, 32'd1);
         checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
         @(negedge clk);
         checkOutput("done_single", {31'b0, done}, 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      multStart = 1'b0;
      divStart  = 1'b0;
      srcA      = '0;
      srcB      = '0;
      #1;
      checkOutput("reset_hi", hiOut, 32'd0);
      checkOutput("reset_lo", loOut, 32'd0);
      checkOutput("reset_flags", {29'b0, busy, done, div0}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      applyStimulus(1, 0, 32'h00000007, 32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
      applyStimulus(1, 0, 32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h00000000, 0);
      applyStimulus(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h3FFFFFFF, 32'h00000001, 0);
      applyStimulus(0, 1, 32'd100,      32'd7,        0, 32'd2,        32'd14,       0);
      applyStimulus(0, 1, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      applyStimulus(0, 1, 32'd7,        32'hFFFFFFFE, 0, 32'd1,        32'hFFFFFFFD, 0);
      applyStimulus(0, 1, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0,        32'h80000000, 0);
      // 0x66 * 0x2AAAAAAB = 0x11_00000022, leaving a recognisable HI/LO pair.
      applyStimulus(1, 0, 32'h00000066, 32'h2AAAAAAB, 0, 32'h00000011, 32'h00000022, 0);
      applyStimulus(0, 1, 32'd1234,     32'd0,        1, 32'h00000011, 32'h00000022, 0);
      applyStimulus(1, 1, 32'd3,        32'd5,        0, 32'd0,        32'd15,       5);

      // Abandon a divide with an asynchronous reset between edges.
      @(negedge clk);
      divStart = 1'b1;
      srcA     = 32'd100;
      srcB     = 32'd7;
      @(negedge clk);
      divStart = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_hi", hiOut, 32'd0);
      checkOutput("async_reset_lo", loOut, 32'd0);
      checkOutput("async_reset_flags", {29'b0, busy, done, div0}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("idle_after_reset", {31'b0, busy}, 32'd0);

      applyStimulus(0, 1, 32'd9, 32'd3, 0, 32'd0, 32'd3, 0);

      repeat (2) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
